adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one adder (2..8).
REQ-002 Parameter W, default 6, operand width, matching the shared adder datapath.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  NREQ  per-requester request; held high with operands stable until granted.
REQ-006 x_in  input  NREQ*W  packed operand x; slice i belongs to requester i.
REQ-007 y_in  input  NREQ*W  packed operand y; slice i belongs to requester i.
REQ-008 gnt  output  NREQ  registered one-hot grant; one-cycle pulse.
REQ-009 res_valid  output  1  result valid.
REQ-010 res_id  output  IDW  index of the requester owning the result; IDW = clog2(NREQ).
REQ-011 res_sum  output  W  sum bits.
REQ-012 res_cout  output  1  carry out.

Function
REQ-013 The block SHALL contain exactly one W-bit adder (x,y -> s,cout), fed only from internal operand registers x_r, y_r.
REQ-014 Arbitration SHALL be round-robin: search starts at index ptr, wraps from NREQ-1 to 0; the first eligible req wins.
REQ-015 A requester SHALL be eligible only if req[i]=1 and gnt[i]=0 in the current cycle (no back-to-back grant to the same requester).
REQ-016 On the edge a winner i is selected: x_r/y_r/id_r capture slice i, gnt becomes one-hot i for exactly one cycle, ptr becomes (i+1) mod NREQ.
REQ-017 On the following edge: res_sum/res_cout register the adder output, res_id <= id_r, res_valid <= 1.
REQ-018 Latency SHALL be 2 cycles from the req-sampling edge to res_valid; throughput up to one result per cycle.
REQ-019 res_valid SHALL be 1 for exactly one cycle per grant when no stall exists; res_* hold their last value when res_valid=0.
REQ-020 With no eligible request, gnt=0, ptr unchanged, no operand capture.
REQ-021 Addition SHALL be unsigned modulo 2^W; {res_cout,res_sum} = x+y exactly (e.g. 63+63 -> cout=1, sum=62).
REQ-022 FSM states: IDLE (no op in flight), BUSY (operand registers hold an op), HOLD (macro only, REQ-027). IDLE->BUSY on grant; BUSY->BUSY on grant; BUSY->IDLE with no grant.
REQ-023 A req dropped before grant SHALL be ignored; no result produced for it.

Reset
REQ-024 While rst_n=0 at a clock edge: gnt=0, res_valid=0, res_sum=0, res_cout=0, res_id=0, ptr=0, x_r=y_r=0, state=IDLE.
REQ-025 Reset asserted mid-operation SHALL discard the in-flight op; no res_valid for it after rst_n returns high.
REQ-026 First arbitration SHALL occur on the first edge with rst_n=1.

Configuration
REQ-027 With ADDER_ARB_STALL_EN defined: input res_ready (1 bit) exists; if res_valid=1 and res_ready=0, state=HOLD, res_* and operand registers hold, no new grants; exit HOLD on the edge where res_ready=1.
REQ-028 Without ADDER_ARB_STALL_EN: no res_ready port, no HOLD state; results are never stalled.

Structure
REQ-029 Package adder_arb_pkg SHALL hold W, NREQ defaults, IDW, and the FSM state enum (IDLE, BUSY, HOLD).
REQ-030 Sub-module rr_pick SHALL implement the combinational round-robin selection (req, mask, ptr -> one-hot winner, index, any).
REQ-031 The existing adder module SHALL be instantiated unmodified as the shared datapath.

Verification
REQ-032 Reset: hold rst_n=0 3 cycles with req=4'b1111 -> gnt=0, res_valid=0, all res_* = 0.
REQ-033 Single: req[2]=1, x2=6'd37, y2=6'd30 -> gnt=4'b0100 one cycle; next cycle res_valid=1, res_id=2, sum=6'd3, cout=1.
REQ-034 Fairness: req=4'b1111 held continuously -> grants 0,1,2,3,0 in consecutive cycles, res_valid every cycle after the first two.
REQ-035 Wrap/mask: ptr=3, req=4'b1001 -> grant 3 then 0; requester 3 never granted twice in a row.
REQ-036 Mid-op reset: grant requester 1, assert rst_n=0 next edge -> no res_valid with res_id=1 afterward.
REQ-037 Exhaustive: all 64x64 operand pairs via requester 0 -> {res_cout,res_sum} == x+y every result; with ADDER_ARB_STALL_EN, res_ready=0 for 5 cycles -> outputs frozen, gnt=0.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the round-robin adder arbiter.
// Build option ADDER_ARB_STALL_EN adds a res_ready back-pressure input and the HOLD state.
package adder_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 6;
    localparam int IDW_DEF  = $clog2(NREQ_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

    // Pointer advance with wrap from n-1 back to 0.
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/adder.sv
// Shared W-bit unsigned adder datapath: {cout, s} = x + y.
module adder #(
    parameter int W = 6
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible request at or after ptr, wrapping.
module rr_pick #(
    parameter int  N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [N-1:0]   elig_s;
    logic [IDW-1:0] cand_s;
    logic           found_s;

    assign elig_s = req & mask;

    // Scan N candidates starting at ptr; the first hit wins.
    always_comb begin
        found_s = 1'b0;
        idx     = '0;
        cand_s  = '0;
        onehot  = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = IDW'((int'(ptr) + k) % N);
            if (!found_s && elig_s[cand_s]) begin
                found_s = 1'b1;
                idx     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        onehot[idx] = found_s;
        any         = found_s;
    end

endmodule

// File: rtl/adder_arbiter.sv
// NREQ requesters share one adder through a round-robin arbiter; results appear one edge after the grant.
// Optional ADDER_ARB_STALL_EN adds res_ready; a refused result freezes the pipe in HOLD.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int  NREQ = NREQ_DEF,
    parameter int  W    = W_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ADDER_ARB_STALL_EN
    input  logic              res_ready,
`endif
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] x_in,
    input  logic [NREQ*W-1:0] y_in,
    output logic [NREQ-1:0]   gnt,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [W-1:0]      res_sum,
    output logic              res_cout
);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]    x_q, x_d, y_q, y_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            res_valid_q, res_valid_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [W-1:0]    res_sum_q, res_sum_d;
    logic            res_cout_q, res_cout_d;

    logic [NREQ-1:0] pick_onehot_s;
    logic [IDW-1:0]  pick_idx_s;
    logic            pick_any_s;
    logic [W-1:0]    sel_x_s, sel_y_s;
    logic [W-1:0]    add_sum_s;
    logic            add_cout_s;
    logic            stall_s;
    logic            op_live_s;

    adder #(.W(W)) u_adder (
        .x    (x_q),
        .y    (y_q),
        .s    (add_sum_s),
        .cout (add_cout_s)
    );

    // A requester granted last cycle is masked out this cycle.
    rr_pick #(.N(NREQ)) u_pick (
        .req    (req),
        .mask   (~gnt_q),
        .ptr    (ptr_q),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

`ifdef ADDER_ARB_STALL_EN
    logic hold_op_q, hold_op_d;
    assign stall_s   = res_valid_q & ~res_ready;
    assign op_live_s = (state_q == BUSY) | ((state_q == HOLD) & hold_op_q);
`else
    assign stall_s   = 1'b0;
    assign op_live_s = (state_q == BUSY);
`endif

    // AND-OR mux of the winning requester's operand slices.
    always_comb begin
        sel_x_s = '0;
        sel_y_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_x_s = sel_x_s | (x_in[i*W +: W] & {W{pick_onehot_s[i]}});
            sel_y_s = sel_y_s | (y_in[i*W +: W] & {W{pick_onehot_s[i]}});
        end
    end

    // Next-state: stall freezes everything, otherwise retire the live op and accept a new winner.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        x_d         = x_q;
        y_d         = y_q;
        id_d        = id_q;
        gnt_d       = '0;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
`ifdef ADDER_ARB_STALL_EN
        hold_op_d   = hold_op_q;
`endif
        if (stall_s) begin
            state_d     = HOLD;
            res_valid_d = res_valid_q;
`ifdef ADDER_ARB_STALL_EN
            hold_op_d   = op_live_s;
`endif
        end else begin
            if (op_live_s) begin
                res_valid_d = 1'b1;
                res_id_d    = id_q;
                res_sum_d   = add_sum_s;
                res_cout_d  = add_cout_s;
            end else begin
                res_valid_d = 1'b0;
            end
            if (pick_any_s) begin
                x_d     = sel_x_s;
                y_d     = sel_y_s;
                id_d    = pick_idx_s;
                gnt_d   = pick_onehot_s;
                ptr_d   = IDW'(wrap_inc(int'(pick_idx_s), NREQ));
                state_d = BUSY;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
`ifdef ADDER_ARB_STALL_EN
            hold_op_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
`ifdef ADDER_ARB_STALL_EN
            hold_op_q   <= hold_op_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;

endmodule
